// File: rtl/ex_stall_hazard_if.sv
// EX-stage stall/hazard bundle: pipeline-side inputs and ID/EX control outputs.
interface ex_stall_hazard_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAW   = 5,
    parameter int unsigned CNT_W = 32
) ();
    logic             ext_stall;
    logic [RAW-1:0]   ID_EX_rs1;
    logic [RAW-1:0]   ID_EX_rs2;
    logic [RAW-1:0]   EX_MEM_rd;
    logic             EX_MEM_memread;
    logic             EX_MEM_regwrite;
    logic             dmem_ready;
    logic [RAW-1:0]   MEM_WB_rd;
    logic             MEM_WB_regwrite;
    logic [XLEN-1:0]  MEM_WB_result;
    logic             EX_stall;
    logic             EX_hazard_rs1_data_enable;
    logic [XLEN-1:0]  EX_hazard_rs1_data;
    logic             EX_hazard_rs2_data_enable;
    logic [XLEN-1:0]  EX_hazard_rs2_data;
    logic             EX_MEM_bubble;
    logic [CNT_W-1:0] stall_cycles;
    logic             protocol_error;

    // Pipeline side: drives hazard inputs, observes stall controls.
    modport master (
        output ext_stall, ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, EX_MEM_memread, EX_MEM_regwrite,
        output dmem_ready, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_result,
        input  EX_stall, EX_hazard_rs1_data_enable, EX_hazard_rs1_data,
        input  EX_hazard_rs2_data_enable, EX_hazard_rs2_data, EX_MEM_bubble,
        input  stall_cycles, protocol_error
    );

    // Hazard unit side.
    modport slave (
        input  ext_stall, ID_EX_rs1, ID_EX_rs2, EX_MEM_rd, EX_MEM_memread, EX_MEM_regwrite,
        input  dmem_ready, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_result,
        output EX_stall, EX_hazard_rs1_data_enable, EX_hazard_rs1_data,
        output EX_hazard_rs2_data_enable, EX_hazard_rs2_data, EX_MEM_bubble,
        output stall_cycles, protocol_error
    );
endinterface

// File: rtl/ex_stall_hazard_unit.sv
// EX-stage stall and operand-capture controller: load-use detection, memory-latency hold,
// load-result injection and WB forwarding into the held ID/EX operands.
module ex_stall_hazard_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RAW   = 5,
    parameter int unsigned CNT_W = 32
) (
    input logic             clk,
    input logic             reset,
    ex_stall_hazard_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StWaitMem, StCapture} state_e;

    state_e           state_q, state_d;
    logic [1:0]       match_q, match_d;   // [0]=rs1, [1]=rs2 waits on the load
    logic [RAW-1:0]   ld_rd_q, ld_rd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [1:0] lu;
    logic [1:0] wb;
    logic       load_hz;
    logic       stall;
    logic       bubble;
    logic [1:0] en;

    // Hazard terms; x0 never matches.
    always_comb begin
        lu[0] = bus.EX_MEM_memread & bus.EX_MEM_regwrite & (bus.EX_MEM_rd != '0) &
                (bus.EX_MEM_rd == bus.ID_EX_rs1);
        lu[1] = bus.EX_MEM_memread & bus.EX_MEM_regwrite & (bus.EX_MEM_rd != '0) &
                (bus.EX_MEM_rd == bus.ID_EX_rs2);
        wb[0] = bus.MEM_WB_regwrite & (bus.MEM_WB_rd != '0) & (bus.MEM_WB_rd == bus.ID_EX_rs1);
        wb[1] = bus.MEM_WB_regwrite & (bus.MEM_WB_rd != '0) & (bus.MEM_WB_rd == bus.ID_EX_rs2);
        load_hz = |lu;
    end

    // Next-state and stall/capture decode.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        ld_rd_d = ld_rd_q;
        err_d   = err_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        en      = 2'b00;
        unique case (state_q)
            StIdle: begin
                stall  = load_hz | bus.ext_stall;
                bubble = load_hz & ~bus.ext_stall;
                // An operand that waits on the load must not take the stale WB value.
                en     = {2{stall}} & wb & ~lu;
                if (load_hz) begin
                    match_d = lu;
                    ld_rd_d = bus.EX_MEM_rd;
                    state_d = bus.dmem_ready ? StCapture : StWaitMem;
                end
            end
            StWaitMem: begin
                // Load is held in MEM by its own stall, so no bubble here.
                stall = 1'b1;
                en    = wb & ~match_q;
                if (bus.dmem_ready) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                stall = 1'b1;
                en    = match_q | wb;
                if (!(bus.MEM_WB_regwrite && (bus.MEM_WB_rd == ld_rd_q))) begin
                    err_d = 1'b1;
                end
                match_d = 2'b00;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, latched load info and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            match_q <= 2'b00;
            ld_rd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            ld_rd_q <= ld_rd_d;
            err_q   <= err_d;
        end
    end

    // Free-running stall performance counter, wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Combinational outputs are held at zero throughout reset.
    always_comb begin
        bus.EX_stall                  = ~reset & stall;
        bus.EX_MEM_bubble             = ~reset & bubble;
        bus.EX_hazard_rs1_data_enable = ~reset & en[0];
        bus.EX_hazard_rs2_data_enable = ~reset & en[1];
        bus.EX_hazard_rs1_data        = reset ? {XLEN{1'b0}} : bus.MEM_WB_result;
        bus.EX_hazard_rs2_data        = reset ? {XLEN{1'b0}} : bus.MEM_WB_result;
        bus.stall_cycles              = stall_cnt_q;
        bus.protocol_error            = err_q;
    end
endmodule

// File: tb/tb_ex_stall_hazard_unit.sv
// Directed bench for ex_stall_hazard_unit. Inputs change 1 time unit after the rising
// edge; outputs are sampled 2 units later, well clear of the edge.
module tb_ex_stall_hazard_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [3:0] obs;  // {EX_stall, EX_MEM_bubble, rs1_enable, rs2_enable}

    ex_stall_hazard_if bus ();

    ex_stall_hazard_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.ext_stall       = 1'b0;
        bus.ID_EX_rs1       = '0;
        bus.ID_EX_rs2       = '0;
        bus.EX_MEM_rd       = '0;
        bus.EX_MEM_memread  = 1'b0;
        bus.EX_MEM_regwrite = 1'b0;
        bus.dmem_ready      = 1'b1;
        bus.MEM_WB_rd       = '0;
        bus.MEM_WB_regwrite = 1'b0;
        bus.MEM_WB_result   = '0;
    endtask

    task automatic set_load(input logic [4:0] rd, input logic ready);
        bus.EX_MEM_rd       = rd;
        bus.EX_MEM_memread  = 1'b1;
        bus.EX_MEM_regwrite = 1'b1;
        bus.dmem_ready      = ready;
    endtask

    task automatic set_wb(input logic [4:0] rd, input logic [31:0] val);
        bus.MEM_WB_rd       = rd;
        bus.MEM_WB_regwrite = 1'b1;
        bus.MEM_WB_result   = val;
    endtask

    task automatic apply_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        bus.ext_stall = 1'b1;
        set_wb(5'd3, 32'hA5A5_A5A5);
        bus.ID_EX_rs1 = 5'd3;
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL reset_ctrl got %b want 0000", obs);
        else n_pass++;
        n_checks++;
        if (bus.EX_hazard_rs1_data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.EX_hazard_rs1_data);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.stall_cycles !== 32'd0) $display("FAIL reset_cnt got %0d want 0", bus.stall_cycles);
        else n_pass++;
        n_checks++;
        if (bus.protocol_error !== 1'b0) $display("FAIL reset_perr got %b want 0", bus.protocol_error);
        else n_pass++;
        reset = 1'b0;
        set_idle();
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL reset_idle got %b want 0000", obs);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use_ready();
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        set_load(5'd5, 1'b1);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL lu_c1 got %b want 1100", obs);
        else n_pass++;
        tick();
        bus.EX_MEM_memread = 1'b0;
        bus.EX_MEM_regwrite = 1'b0;
        set_wb(5'd5, 32'hDEAD_BEEF);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1010) $display("FAIL lu_c2 got %b want 1010", obs);
        else n_pass++;
        n_checks++;
        if (bus.EX_hazard_rs1_data !== 32'hDEAD_BEEF)
            $display("FAIL lu_data got %h want deadbeef", bus.EX_hazard_rs1_data);
        else n_pass++;
        tick();
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        #2;
        n_checks++;
        if (bus.stall_cycles !== 32'd2) $display("FAIL lu_cnt got %0d want 2", bus.stall_cycles);
        else n_pass++;
        n_checks++;
        if (bus.EX_stall !== 1'b0) $display("FAIL lu_release got %b want 0", bus.EX_stall);
        else n_pass++;
        n_checks++;
        if (bus.protocol_error !== 1'b0) $display("FAIL lu_perr got %b want 0", bus.protocol_error);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_use_wait();
        logic [3:0] want [5] = '{4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b1010};
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) set_load(5'd5, 1'b0);
            else if (c == 3) set_load(5'd5, 1'b1);
            else begin
                bus.EX_MEM_memread = 1'b0;
                bus.EX_MEM_regwrite = 1'b0;
                set_wb(5'd5, 32'hDEAD_BEEF);
            end
            #2;
            obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
                   bus.EX_hazard_rs2_data_enable};
            n_checks++;
            if (obs !== want[c]) $display("FAIL wait_c%0d got %b want %b", c + 1, obs, want[c]);
            else n_pass++;
            tick();
        end
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        #2;
        n_checks++;
        if (bus.stall_cycles !== 32'd5) $display("FAIL wait_cnt got %0d want 5", bus.stall_cycles);
        else n_pass++;
        n_checks++;
        if (bus.EX_stall !== 1'b0) $display("FAIL wait_release got %b want 0", bus.EX_stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_ext_stall();
        apply_reset();
        set_idle();
        bus.ext_stall = 1'b1;
        bus.ID_EX_rs1 = 5'd3;
        bus.ID_EX_rs2 = 5'd7;
        set_wb(5'd7, 32'h12);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1001) $display("FAIL ext_ctrl got %b want 1001", obs);
        else n_pass++;
        n_checks++;
        if (bus.EX_hazard_rs2_data !== 32'h12) $display("FAIL ext_data got %h want 12", bus.EX_hazard_rs2_data);
        else n_pass++;
        tick();
        bus.ext_stall = 1'b0;
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL ext_release got %b want 0000", obs);
        else n_pass++;
        n_checks++;
        if (bus.stall_cycles !== 32'd1) $display("FAIL ext_cnt got %0d want 1", bus.stall_cycles);
        else n_pass++;
        tick();
    endtask

    task automatic test_load_and_wb();
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd4;
        bus.ID_EX_rs2 = 5'd9;
        set_load(5'd4, 1'b1);
        set_wb(5'd9, 32'h55);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1101) $display("FAIL mix_c1 got %b want 1101", obs);
        else n_pass++;
        n_checks++;
        if (bus.EX_hazard_rs2_data !== 32'h55) $display("FAIL mix_c1_data got %h want 55", bus.EX_hazard_rs2_data);
        else n_pass++;
        tick();
        bus.EX_MEM_memread = 1'b0;
        bus.EX_MEM_regwrite = 1'b0;
        set_wb(5'd4, 32'hCAFE_0004);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1010) $display("FAIL mix_c2 got %b want 1010", obs);
        else n_pass++;
        n_checks++;
        if (bus.EX_hazard_rs1_data !== 32'hCAFE_0004)
            $display("FAIL mix_c2_data got %h want cafe0004", bus.EX_hazard_rs1_data);
        else n_pass++;
        tick();
    endtask

    task automatic test_both_match();
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd8;
        bus.ID_EX_rs2 = 5'd8;
        set_load(5'd8, 1'b1);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1100) $display("FAIL both_c1 got %b want 1100", obs);
        else n_pass++;
        tick();
        bus.EX_MEM_memread = 1'b0;
        bus.EX_MEM_regwrite = 1'b0;
        set_wb(5'd8, 32'h0000_0888);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b1011) $display("FAIL both_c2 got %b want 1011", obs);
        else n_pass++;
        tick();
    endtask

    task automatic test_x0();
        apply_reset();
        set_idle();
        set_load(5'd0, 1'b1);
        set_wb(5'd0, 32'h77);
        #2;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL x0_ctrl got %b want 0000", obs);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        set_load(5'd5, 1'b0);
        tick();
        set_wb(5'd2, 32'h1234_5678);
        #2;
        n_checks++;
        if (bus.EX_stall !== 1'b1) $display("FAIL rstw_waiting got %b want 1", bus.EX_stall);
        else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        obs = {bus.EX_stall, bus.EX_MEM_bubble, bus.EX_hazard_rs1_data_enable,
               bus.EX_hazard_rs2_data_enable};
        n_checks++;
        if (obs !== 4'b0000) $display("FAIL rstw_ctrl got %b want 0000", obs);
        else n_pass++;
        n_checks++;
        if (bus.stall_cycles !== 32'd0) $display("FAIL rstw_cnt got %0d want 0", bus.stall_cycles);
        else n_pass++;
        tick();
        reset = 1'b0;
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        #2;
        n_checks++;
        if (bus.EX_stall !== 1'b0) $display("FAIL rstw_idle got %b want 0", bus.EX_stall);
        else n_pass++;
        tick();
    endtask

    task automatic test_protocol_error();
        apply_reset();
        set_idle();
        bus.ID_EX_rs1 = 5'd5;
        set_load(5'd5, 1'b1);
        tick();
        bus.EX_MEM_memread = 1'b0;
        bus.EX_MEM_regwrite = 1'b0;
        set_wb(5'd6, 32'h66);
        #2;
        n_checks++;
        if (bus.protocol_error !== 1'b0) $display("FAIL perr_pre got %b want 0", bus.protocol_error);
        else n_pass++;
        tick();
        set_idle();
        #2;
        n_checks++;
        if (bus.protocol_error !== 1'b1) $display("FAIL perr_set got %b want 1", bus.protocol_error);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (bus.protocol_error !== 1'b1) $display("FAIL perr_sticky got %b want 1", bus.protocol_error);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.protocol_error !== 1'b0) $display("FAIL perr_clear got %b want 0", bus.protocol_error);
        else n_pass++;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        set_idle();
        tick();
        test_reset();
        test_load_use_ready();
        test_load_use_wait();
        test_ext_stall();
        test_load_and_wb();
        test_both_match();
        test_x0();
        test_reset_mid_wait();
        test_protocol_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ex_stall_hazard_unit.md
Name: ex_stall_hazard_unit

Overview:
- Stall and operand-capture controller for the EX stage.
- Drives the EX_stall and EX_hazard_rs{1,2}_data{,_enable} inputs of the ID/EX pipeline register.
- Detects load-use hazards between EX and MEM, and holds EX through the load's memory latency. It then injects the load result into the held ID/EX operand.
- While EX is stalled for any reason, it captures results retiring from WB so that held operands do not go stale.

Parameters:
XLEN, 32, data width
RAW, 5, register address width
CNT_W, 32, stall performance counter width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
ext_stall  input  1  stall request from a later stage (MEM busy etc.)
ID_EX_rs1  input  RAW  source reg 1 of instruction held in EX
ID_EX_rs2  input  RAW  source reg 2 of instruction held in EX
EX_MEM_rd  input  RAW  destination of instruction in MEM
EX_MEM_memread  input  1  instruction in MEM is a load
EX_MEM_regwrite  input  1  instruction in MEM writes a register
dmem_ready  input  1  data memory completes the MEM-stage access this cycle
MEM_WB_rd  input  RAW  destination of instruction in WB
MEM_WB_regwrite  input  1  instruction in WB writes a register
MEM_WB_result  input  XLEN  write-back value
EX_stall  output  1  hold ID/EX register
EX_hazard_rs1_data_enable  output  1  load rs1 data while stalled
EX_hazard_rs1_data  output  XLEN  rs1 capture value
EX_hazard_rs2_data_enable  output  1  load rs2 data while stalled
EX_hazard_rs2_data  output  XLEN  rs2 capture value
EX_MEM_bubble  output  1  insert a bubble into EX/MEM next edge (load-use stall only)
stall_cycles  output  CNT_W  count of cycles with EX_stall=1, wraps
protocol_error  output  1  sticky: WB destination mismatch in CAPTURE

Behaviour:
- Reset: state=IDLE, match1/match2/ld_rd regs=0, stall_cycles=0, protocol_error=0.
- While reset is asserted, all combinational outputs are forced to 0.
- Definitions:
  - lu_i = EX_MEM_memread & EX_MEM_regwrite & EX_MEM_rd!=0 & EX_MEM_rd==ID_EX_rs_i.
  - wb_i = MEM_WB_regwrite & MEM_WB_rd!=0 & MEM_WB_rd==ID_EX_rs_i.
- EX_hazard_rs1_data and EX_hazard_rs2_data always equal MEM_WB_result.
- Enables are only asserted when EX_stall=1.
- FSM, IDLE state:
  - load_hz = lu_1|lu_2. EX_stall = load_hz|ext_stall. EX_MEM_bubble = load_hz & ~ext_stall.
  - enable_i = EX_stall & wb_i & ~lu_i.
  - If load_hz: latch match_i=lu_i and ld_rd=EX_MEM_rd. Next state is CAPTURE if dmem_ready, else WAIT_MEM.
- FSM, WAIT_MEM state:
  - EX_stall=1. EX_MEM_bubble=0, because the load is held in MEM by its own stall.
  - enable_i = wb_i & ~match_i.
  - Go to CAPTURE when dmem_ready; otherwise stay.
- FSM, CAPTURE state:
  - The load is in WB. EX_stall=1, EX_MEM_bubble=0.
  - enable_i = match_i | wb_i.
  - If ~(MEM_WB_regwrite & MEM_WB_rd==ld_rd), set protocol_error (sticky until reset).
  - Next state is IDLE. match regs are cleared.
- The cycle after CAPTURE is evaluated in IDLE with normal rules. Because EX/MEM then holds a bubble, no repeat load hazard occurs. If ext_stall=1 in that cycle, the stall continues under IDLE rules.
- ext_stall in WAIT_MEM/CAPTURE does not change transitions: EX_stall is already 1, and the load result appears in WB only after dmem_ready.
- Both operands matching (rs1==rs2==ld_rd): both enables assert in CAPTURE.
- rs=x0 never creates a hazard or a capture.
- stall_cycles increments on every clk edge where EX_stall=1 and reset is low. It wraps at 2^CNT_W.
- Reset mid-stall: immediate return to IDLE with all outputs 0. No partial capture is required.
- Latency:
  - Load-use stall with dmem_ready already high: exactly 2 cycles (IDLE-detect, CAPTURE).
  - Each extra WAIT_MEM cycle adds 1.

Test Plan:
1. Load x5 in MEM, EX rs1=5, dmem_ready=1, then MEM_WB_rd=5 and result=0xDEADBEEF. Required:
   - EX_stall=1 for 2 cycles; EX_MEM_bubble=1 in cycle 1 only.
   - rs1_enable=1 in cycle 2 with data 0xDEADBEEF; stall_cycles=2; then EX_stall=0.
2. Same as 1 with dmem_ready low for 3 cycles. Required: EX_stall=1 for 5 cycles, WAIT_MEM visited 3 cycles, enable only in the final cycle, stall_cycles=5.
3. ext_stall=1 for 1 cycle with MEM_WB_rd=7, regwrite=1, result=0x12, EX rs2=7, rs1=3. Required: rs2_enable=1 with data 0x12, rs1_enable=0, no bubble.
4. Load-use on rs1=4 while WB retires rd=9 (result 0x55) and EX rs2=9. Required:
   - Cycle 1: rs2_enable=1 with 0x55, rs1_enable=0.
   - CAPTURE: rs1_enable=1 with the load result.
5. Load x0 in MEM with EX rs1=0, plus MEM_WB_rd=0. Required: EX_stall=0, all enables 0.
6. Reset asserted in WAIT_MEM. Required: outputs 0 immediately, stall_cycles=0, state IDLE. In CAPTURE with MEM_WB_rd=6 vs ld_rd=5: protocol_error=1 and held until reset.
